hyper_resp: RTL
===============

# hyper_resp

Synthesizable HyperBus responder that emulates the memory side of the link driven by `hyper_xface`, so the controller can be exercised in fast RTL or emulation runs without the vendor timing model. It samples the controller's `dram_ck`, `dram_cs_l`, `dram_dq` and `dram_rwds` in the system clock domain and detects each CK edge as one event. It decodes the 48-bit command/address, counts a fixed 2x initial latency, and services linear or wrapped 16-bit word bursts against an internal memory array.

## Interface
Parameters:
- `MEM_AW`, 10: word-address width of the internal array (2^MEM_AW × 16-bit words).
- `LAT_EDGES`, 22: CK edges strictly between the last CA edge (edge 5) and the first data edge for memory accesses.
- `ID0`, 16'h0C81: value returned by a register read at register word address 0x0000.
- `CR0_RST`, 16'h8F1F: reset value of CR0, at register word address 0x0800.

Ports:
- `clk` in 1: system clock. One clock; every input is sampled on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `dram_ck` in 1: HyperBus CK from the controller. It toggles at most once per `clk`.
- `dram_cs_l` in 1: chip select, active low.
- `dram_rst_l` in 1: device reset, active low.
- `dram_dq_in` in 8: DQ from the controller.
- `dram_dq_out` out 8: DQ driven by the responder.
- `dram_dq_oe_l` out 1: DQ output enable, active low.
- `dram_rwds_in` in 1: RWDS from the controller, carrying the write byte mask.
- `dram_rwds_out` out 1: RWDS driven by the responder.
- `dram_rwds_oe_l` out 1: RWDS output enable, active low.

## Operation
- Edge detect:
  - `ck_q` is a registered copy of `dram_ck`.
  - `edge = dram_ck ^ ck_q` while CS is low.
  - `edge_cnt` counts detected edges from CS fall; the first CA edge is edge 0.
- States: IDLE, CA, LAT, WDATA, RDATA.
  - IDLE→CA on `dram_cs_l` falling.
  - CA collects 6 bytes, MSB first, on edges 0–5.
  - At edge 5: read → LAT; memory write → LAT; register write → WDATA with zero latency (data on edges 6, 7).
  - LAT→RDATA or WDATA after LAT_EDGES further edges.
- CA decode:
  - CA[47]=1 is a read.
  - CA[46]=1 selects register space.
  - CA[45]=1 is a linear burst.
  - Word address is {CA[44:16], CA[2:0]}, truncated to MEM_AW bits.
- RWDS handling:
  - From CS fall through edge 5: drive `dram_rwds_out`=1 with `dram_rwds_oe_l`=0, signalling fixed 2x latency.
  - After edge 5, release RWDS except while in RDATA.
- Write data:
  - Even data edge captures byte [15:8]; odd data edge captures byte [7:0].
  - `dram_rwds_in`=1 on that edge masks the byte.
  - The word is committed at the odd edge; the address then increments.
- Read data:
  - Each data edge loads the next byte into `dram_dq_out` one `clk` later, with `dram_dq_oe_l`=0 and `dram_rwds_out` = 1 for [15:8] bytes and 0 for [7:0] bytes.
  - Word data is fetched from the array when the [15:8] byte is issued.
- Burst addressing:
  - Linear bursts wrap modulo 2^MEM_AW.
  - Wrapped bursts wrap within the aligned 16-word group (address[3:0] increments; upper bits are held).
- Registers: reads of 0x0000 return ID0, reads of 0x0800 return CR0, and all other reads return 0. A write to 0x0800 updates CR0; other register writes are ignored.

## Timing
- Reset (`reset`=1, or `dram_rst_l`=0 outside a transaction): state IDLE, `dram_dq_out`=0, `dram_dq_oe_l`=1, `dram_rwds_out`=0, `dram_rwds_oe_l`=1, CR0=CR0_RST. Array contents are retained.
- Reset mid-transaction takes effect in the same cycle. No further writes are committed.
- CS rising in any state: next `clk` returns to IDLE with both output enables deasserted. A half-collected write word is discarded. Already-committed words remain.
- CS falling while in IDLE with `dram_ck`=1: CA still starts on the next detected edge.
- Read latency: first read byte is driven 1 `clk` after data edge 6+LAT_EDGES.
- Output enables deassert 1 `clk` after CS rises.
- A simultaneous edge and CS rise counts as abort; that edge is ignored.

## Configuration
- `HYPER_RESP_REG_EN` defined: register space is decoded as described above.
- `HYPER_RESP_REG_EN` undefined:
  - Register-space reads follow memory read timing and return 16'h0000.
  - Register-space writes follow zero-latency timing and are discarded.
  - CR0 logic is removed.

## Test plan
- Write 16'hA5C3 to word 0x010, then read 1 dword from 0x010 → read data A5C3 followed by the word at 0x011, with RWDS toggling 1,0,1,0.
- Write 16'hFFFF to 0x020 with RWDS=1 on the [7:0] byte, after word 0x020 was preset to 0x1234 → readback 0xFF34.
- Linear 4-word write starting at 2^MEM_AW−2 → words land at addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Wrapped 4-word read starting at 0x01E → words from 0x01E, 0x01F, 0x010, 0x011.
- CS deasserted after the first write data byte at 0x030 → 0x030 unchanged; outputs tristate 1 `clk` after CS rise; the next transaction decodes normally.
- With `HYPER_RESP_REG_EN` defined, register read at 0x0000 → 0x0C81; register write of 0x8F17 to 0x0800, then read → 0x8F17. Assert `reset` mid-read → `dram_dq_oe_l`=1 on the same cycle.

Source files
------------

// File: rtl/hyper_resp.sv
// rtl/hyper_resp.sv - HyperBus memory-side responder; HYPER_RESP_REG_EN enables the ID0/CR0 register space.
module hyper_resp #(
    parameter int          MEM_AW    = 10,
    parameter int          LAT_EDGES = 22,
    parameter logic [15:0] ID0       = 16'h0C81,
    parameter logic [15:0] CR0_RST   = 16'h8F1F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dram_ck,
    input  logic       dram_cs_l,
    input  logic       dram_rst_l,
    input  logic [7:0] dram_dq_in,
    output logic [7:0] dram_dq_out,
    output logic       dram_dq_oe_l,
    input  logic       dram_rwds_in,
    output logic       dram_rwds_out,
    output logic       dram_rwds_oe_l
);
    localparam int CW = $clog2(LAT_EDGES + 8) + 1;
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]     CA_LAST  = CW'(5);
    localparam logic [CW-1:0]     LAT_LAST = CW'(LAT_EDGES - 1);
    localparam logic [MEM_AW-1:0] ADDR_ONE = MEM_AW'(1);

    typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_WDATA, S_RDATA} state_t;

    state_t            state_q, state_d, cur;
    logic              ck_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [47:0]       ca_q, ca_d, ca_next;
    logic [31:0]       waddr_next;
    logic [MEM_AW-1:0] addr_q, addr_d, addr_inc;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d, lo_q, lo_d;
    logic              hi_m_q, hi_m_d;
    logic [7:0]        dq_out_q, dq_out_d;
    logic              dq_oe_l_q, dq_oe_l_d;
    logic              rwds_out_q, rwds_out_d;
    logic              rwds_oe_l_q, rwds_oe_l_d;
    logic [15:0]       mem [2**MEM_AW];
    logic [15:0]       mem_word, rd_word, wr_word, wr_base, reg_rd;
    logic              ck_edge, dev_rst, commit, mem_we;
    logic              unused_bits;

    // The device-reset pin only acts between transactions; the system reset acts anywhere.
    assign dev_rst    = reset | (~dram_rst_l & (state_q == S_IDLE));
    assign ck_edge    = (dram_ck ^ ck_q) & ~dram_cs_l;
    assign ca_next    = {ca_q[39:0], dram_dq_in};
    assign waddr_next = {ca_next[44:16], ca_next[2:0]};
    assign mem_word   = mem[addr_q];
    assign addr_inc   = ca_q[45] ? addr_q + ADDR_ONE
                                 : {addr_q[MEM_AW-1:4], addr_q[3:0] + 4'd1};
    assign rd_word    = ca_q[46] ? reg_rd : mem_word;
    assign wr_word    = {hi_m_q ? wr_base[15:8] : hi_q,
                         dram_rwds_in ? wr_base[7:0] : dram_dq_in};
    assign mem_we     = commit & ~ca_q[46] & ~dev_rst;
    assign unused_bits = ^{waddr_next[31:MEM_AW], ca_q[44:40]};

`ifdef HYPER_RESP_REG_EN
    logic [15:0] cr0_q, cr0_d;
    logic [31:0] reg_addr;

    assign reg_addr = {ca_q[44:16], ca_q[2:0]};
    assign reg_rd   = (reg_addr == 32'h0000_0000) ? ID0 :
                      (reg_addr == 32'h0000_0800) ? cr0_q : 16'h0000;
    assign wr_base  = ca_q[46] ? cr0_q : mem_word;
    assign cr0_d    = (commit && ca_q[46] && reg_addr == 32'h0000_0800) ? wr_word : cr0_q;

    always_ff @(posedge clk) begin
        if (dev_rst) cr0_q <= CR0_RST;
        else         cr0_q <= cr0_d;
    end
`else
    assign reg_rd  = 16'h0000;
    assign wr_base = mem_word;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ca_d        = ca_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        hi_m_d      = hi_m_q;
        dq_out_d    = dq_out_q;
        dq_oe_l_d   = dq_oe_l_q;
        rwds_out_d  = rwds_out_q;
        rwds_oe_l_d = rwds_oe_l_q;
        commit      = 1'b0;
        // A CS fall seen in IDLE is handled as CA immediately so an edge in that same cycle is not lost.
        cur         = (state_q == S_IDLE) ? S_CA : state_q;
        if (dram_cs_l) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            phase_d     = 1'b0;
            dq_out_d    = 8'h00;
            dq_oe_l_d   = 1'b1;
            rwds_out_d  = 1'b0;
            rwds_oe_l_d = 1'b1;
        end else begin
            state_d = cur;
            unique case (cur)
                S_CA: begin
                    rwds_out_d  = 1'b1;
                    rwds_oe_l_d = 1'b0;
                    if (ck_edge) begin
                        ca_d  = ca_next;
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q == CA_LAST) begin
                            cnt_d       = '0;
                            phase_d     = 1'b0;
                            addr_d      = waddr_next[MEM_AW-1:0];
                            rwds_out_d  = 1'b0;
                            rwds_oe_l_d = 1'b1;
                            state_d     = (!ca_next[47] && ca_next[46]) ? S_WDATA : S_LAT;
                        end
                    end
                end
                S_LAT: begin
                    if (ck_edge) begin
                        if (cnt_q == LAT_LAST) begin
                            cnt_d   = '0;
                            state_d = ca_q[47] ? S_RDATA : S_WDATA;
                            if (ca_q[47]) begin
                                rwds_out_d  = 1'b0;
                                rwds_oe_l_d = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                S_WDATA: begin
                    if (ck_edge) begin
                        if (!phase_q) begin
                            hi_d    = dram_dq_in;
                            hi_m_d  = dram_rwds_in;
                            phase_d = 1'b1;
                        end else begin
                            commit  = 1'b1;
                            addr_d  = addr_inc;
                            phase_d = 1'b0;
                        end
                    end
                end
                S_RDATA: begin
                    rwds_oe_l_d = 1'b0;
                    if (ck_edge) begin
                        dq_oe_l_d = 1'b0;
                        if (!phase_q) begin
                            dq_out_d   = rd_word[15:8];
                            lo_d       = rd_word[7:0];
                            rwds_out_d = 1'b1;
                            phase_d    = 1'b1;
                        end else begin
                            dq_out_d   = lo_q;
                            rwds_out_d = 1'b0;
                            addr_d     = addr_inc;
                            phase_d    = 1'b0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        ck_q <= dram_ck;
        if (dev_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ca_q        <= '0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            hi_q        <= 8'h00;
            lo_q        <= 8'h00;
            hi_m_q      <= 1'b0;
            dq_out_q    <= 8'h00;
            dq_oe_l_q   <= 1'b1;
            rwds_out_q  <= 1'b0;
            rwds_oe_l_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ca_q        <= ca_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            hi_m_q      <= hi_m_d;
            dq_out_q    <= dq_out_d;
            dq_oe_l_q   <= dq_oe_l_d;
            rwds_out_q  <= rwds_out_d;
            rwds_oe_l_q <= rwds_oe_l_d;
        end
    end

    // Array has no reset so its contents survive both reset sources.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= wr_word;
    end

    // Enables are forced off combinationally so a mid-transaction reset releases the bus at once.
    assign dram_dq_out    = dq_out_q;
    assign dram_dq_oe_l   = dq_oe_l_q | reset;
    assign dram_rwds_out  = rwds_out_q;
    assign dram_rwds_oe_l = rwds_oe_l_q | reset;
endmodule
